// File: rtl/full_adder4_pkg.sv
// Shared constants for the registered ripple-carry adder.
package full_adder4_pkg;

   localparam int unsigned FA4_WIDTH = 4;

endpackage : full_adder4_pkg

// File: rtl/full_adder4_bit.sv
// One-bit full-adder cell; the building block of the ripple chain.
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic co
);

   logic p;

   assign p  = a ^ b;
   assign s  = p ^ c;
   assign co = (a & b) | (c & p);

endmodule : full_adder_bit

// File: rtl/full_adder4.sv
// Registered WIDTH-bit ripple-carry adder with carry-out, signed overflow
// and a one-cycle valid qualifier.
module full_adder4
   import full_adder4_pkg::*;
#(
   parameter int unsigned WIDTH = FA4_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] ain,
   input  logic [WIDTH-1:0] bin,
   input  logic             cin,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   logic [WIDTH:0]   carry_c;
   logic [WIDTH-1:0] sum_c;
   logic             ovf_c;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   assign carry_c[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_adder_bit u_cell (
         .a  (ain[i]),
         .b  (bin[i]),
         .c  (carry_c[i]),
         .s  (sum_c[i]),
         .co (carry_c[i+1])
      );
   end

   // Signed overflow: carry into the MSB cell disagrees with carry out of it.
   assign ovf_c = carry_c[WIDTH] ^ carry_c[WIDTH-1];

   always_comb begin
      out_valid_d = in_valid;
      sum_d       = sum_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      if (in_valid) begin
         sum_d  = sum_c;
         cout_d = carry_c[WIDTH];
         ovf_d  = ovf_c;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule : full_adder4

// File: tb/tb_full_adder4.sv
// Directed self-checking bench for full_adder4; observed word is
// {out_valid, cout, ovf, sum[3:0]}.
module tb_full_adder4;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [3:0] ain;
   logic [3:0] bin;
   logic       cin;
   logic       out_valid;
   logic [3:0] sum;
   logic       cout;
   logic       ovf;

   int n_pass  = 0;
   int n_total = 0;

   full_adder4 #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .ain       (ain),
      .bin       (bin),
      .cin       (cin),
      .out_valid (out_valid),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive a vector at the falling edge, then wait past the next rising edge.
   task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic c);
      @(negedge clk);
      in_valid = v;
      ain      = a;
      bin      = b;
      cin      = c;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [6:0] obs;
      rst = 1'b1; in_valid = 1'b0; ain = '0; bin = '0; cin = 1'b0;
      #1;
      obs = {out_valid, cout, ovf, sum};
      n_total++;
      if (obs !== 7'b0_0_0_0000) $display("FAIL reset_initial got=%b exp=%b", obs, 7'b0);
      else n_pass++;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_consecutive();
      logic [6:0] obs;
      drive(1'b1, 4'd2, 4'd5, 1'b0);
      obs = {out_valid, cout, ovf, sum};
      n_total++;
      if (obs !== {1'b1, 1'b0, 1'b0, 4'd7}) $display("FAIL add_2_5_0 got=%b exp=%b", obs, {1'b1, 1'b0, 1'b0, 4'd7});
      else n_pass++;
      drive(1'b1, 4'd3, 4'd7, 1'b1);
      obs = {out_valid, cout, ovf, sum};
      n_total++;
      if (obs !== {1'b1, 1'b0, 1'b1, 4'd11}) $display("FAIL add_3_7_1 got=%b exp=%b", obs, {1'b1, 1'b0, 1'b1, 4'd11});
      else n_pass++;
   endtask

   task automatic test_carry_wrap();
      logic [6:0] obs;
      drive(1'b1, 4'd15, 4'd1, 1'b0);
      obs = {out_valid, cout, ovf, sum};
      n_total++;
      if (obs !== {1'b1, 1'b1, 1'b0, 4'd0}) $display("FAIL wrap_15_1_0 got=%b exp=%b", obs, {1'b1, 1'b1, 1'b0, 4'd0});
      else n_pass++;
      drive(1'b1, 4'd15, 4'd15, 1'b1);
      obs = {out_valid, cout, ovf, sum};
      n_total++;
      if (obs !== {1'b1, 1'b1, 1'b0, 4'd15}) $display("FAIL wrap_15_15_1 got=%b exp=%b", obs, {1'b1, 1'b1, 1'b0, 4'd15});
      else n_pass++;
      drive(1'b1, 4'd0, 4'd0, 1'b0);
      obs = {out_valid, cout, ovf, sum};
      n_total++;
      if (obs !== {1'b1, 1'b0, 1'b0, 4'd0}) $display("FAIL zero_0_0_0 got=%b exp=%b", obs, {1'b1, 1'b0, 1'b0, 4'd0});
      else n_pass++;
      // Negative + negative overflowing to positive: 8 + 8 = -16 -> 0, cout=1, ovf=1.
      drive(1'b1, 4'd8, 4'd8, 1'b0);
      obs = {out_valid, cout, ovf, sum};
      n_total++;
      if (obs !== {1'b1, 1'b1, 1'b1, 4'd0}) $display("FAIL neg_ovf_8_8_0 got=%b exp=%b", obs, {1'b1, 1'b1, 1'b1, 4'd0});
      else n_pass++;
   endtask

   task automatic test_hold();
      logic [6:0] obs;
      drive(1'b1, 4'd4, 4'd4, 1'b0);
      obs = {out_valid, cout, ovf, sum};
      n_total++;
      if (obs !== {1'b1, 1'b0, 1'b1, 4'd8}) $display("FAIL hold_load_4_4_0 got=%b exp=%b", obs, {1'b1, 1'b0, 1'b1, 4'd8});
      else n_pass++;
      drive(1'b0, 4'd9, 4'd9, 1'b0);
      obs = {out_valid, cout, ovf, sum};
      n_total++;
      if (obs !== {1'b0, 1'b0, 1'b1, 4'd8}) $display("FAIL hold_idle got=%b exp=%b", obs, {1'b0, 1'b0, 1'b1, 4'd8});
      else n_pass++;
      // Mid-cycle input changes must not reach the registered outputs.
      in_valid = 1'b1; ain = 4'd1; bin = 4'd2; cin = 1'b1;
      #2;
      obs = {out_valid, cout, ovf, sum};
      n_total++;
      if (obs !== {1'b0, 1'b0, 1'b1, 4'd8}) $display("FAIL between_edges got=%b exp=%b", obs, {1'b0, 1'b0, 1'b1, 4'd8});
      else n_pass++;
   endtask

   task automatic test_async_reset();
      logic [6:0] obs;
      drive(1'b1, 4'd15, 4'd15, 1'b1);
      obs = {out_valid, cout, ovf, sum};
      n_total++;
      if (obs !== {1'b1, 1'b1, 1'b0, 4'd15}) $display("FAIL pre_reset_load got=%b exp=%b", obs, {1'b1, 1'b1, 1'b0, 4'd15});
      else n_pass++;
      // Another vector in flight when reset hits; it must be discarded.
      @(negedge clk);
      in_valid = 1'b1; ain = 4'd5; bin = 4'd6; cin = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      obs = {out_valid, cout, ovf, sum};
      n_total++;
      if (obs !== 7'b0) $display("FAIL async_reset got=%b exp=%b", obs, 7'b0);
      else n_pass++;
      @(posedge clk);
      #1;
      obs = {out_valid, cout, ovf, sum};
      n_total++;
      if (obs !== 7'b0) $display("FAIL reset_held_edge got=%b exp=%b", obs, 7'b0);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      drive(1'b1, 4'd1, 4'd1, 1'b1);
      obs = {out_valid, cout, ovf, sum};
      n_total++;
      if (obs !== {1'b1, 1'b0, 1'b0, 4'd3}) $display("FAIL post_reset_1_1_1 got=%b exp=%b", obs, {1'b1, 1'b0, 1'b0, 4'd3});
      else n_pass++;
   endtask

   task automatic test_exhaustive();
      logic [6:0] obs;
      logic [6:0] exp;
      logic [4:0] full;
      logic       sov;
      int         errs;
      errs = 0;
      for (int k = 0; k < 512; k++) begin
         logic [3:0] a;
         logic [3:0] b;
         logic       c;
         a = 4'(k >> 5);
         b = 4'(k >> 1);
         c = 1'(k);
         drive(1'b1, a, b, c);
         full = 5'(a) + 5'(b) + 5'(c);
         sov  = (a[3] == b[3]) && (full[3] != a[3]);
         exp  = {1'b1, full[4], sov, full[3:0]};
         obs  = {out_valid, cout, ovf, sum};
         n_total++;
         if (obs !== exp) begin
            errs++;
            if (errs <= 8) $display("FAIL exhaustive a=%0d b=%0d c=%0d got=%b exp=%b", a, b, c, obs, exp);
         end else begin
            n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_consecutive();
      test_carry_wrap();
      test_hold();
      test_async_reset();
      test_exhaustive();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_full_adder4
